ptw_axi_arbiter: RTL and testbench

Shares the single AXI read master between the instruction-TLB and data-TLB page-table walkers. Each walker issues one-cycle address pulses, one per walk iteration, and waits for a one-cycle PTE data pulse. The arbiter latches these requests and grants them round-robin. It runs the AR/R handshake, routes each PTE back to its owner, and converts AXI errors and timeouts into access faults. It sits between both TLBs and the AXI master.

---
 rtl/ptw_arb_pkg.sv | 27 ++
 rtl/ptw_req_slot.sv | 47 ++++
 rtl/ptw_axi_arbiter.sv | 176 +++++++++++++++++
 tb/tb_ptw_axi_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ptw_arb_pkg.sv
// rtl/ptw_arb_pkg.sv - shared types and constants for the page-table-walker AXI read arbiter
package ptw_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_AR    = 2'd1,
    ST_R     = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam logic       PORT_I     = 1'b0;
  localparam logic       PORT_D     = 1'b1;
  localparam logic [1:0] RRESP_OKAY = 2'b00;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ptw_req_slot.sv
// rtl/ptw_req_slot.sv - per-walker pending flag and address latch with abort/overwrite priority
module ptw_req_slot #(
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  addr_valid,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  abort,
  input  logic                  grant,
  output logic                  req,
  output logic [ADDR_WIDTH-1:0] req_addr
);

  logic                  pending_q, pending_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  // A fresh pulse beats a same-cycle abort; a grant consumes everything.
  always_comb begin
    pending_d = pending_q;
    addr_d    = addr_q;
    if (addr_valid) begin
      addr_d = addr;
    end
    if (grant) begin
      pending_d = 1'b0;
    end else if (addr_valid) begin
      pending_d = 1'b1;
    end else if (abort) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      addr_q    <= '0;
    end else begin
      pending_q <= pending_d;
      addr_q    <= addr_d;
    end
  end

  assign req      = addr_valid | (pending_q & ~abort);
  assign req_addr = addr_valid ? addr : addr_q;

endmodule

// File: rtl/ptw_axi_arbiter.sv
// rtl/ptw_axi_arbiter.sv - round-robin share of one AXI read master between ITLB and DTLB walkers
module ptw_axi_arbiter
  import ptw_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_addr_valid,
  input  logic                  d_addr_valid,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic                  i_abort,
  input  logic                  d_abort,
  output logic                  i_data_valid,
  output logic                  d_data_valid,
  output logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] d_data,
  output logic                  i_access_fault,
  output logic                  d_access_fault,
  output logic                  m_arvalid,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  input  logic                  m_arready,
  input  logic                  m_rvalid,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp,
  output logic                  m_rready,
  output logic                  busy
);

  localparam int              WAIT_W   = (TIMEOUT_CYCLES > 0) ? clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT_CYCLES);
  localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_grant_q, last_grant_d;
  logic                  drop_q, drop_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic                  i_dv_q, i_dv_d, d_dv_q, d_dv_d;
  logic                  i_flt_q, i_flt_d, d_flt_q, d_flt_d;
  logic [DATA_WIDTH-1:0] i_data_q, i_data_d, d_data_q, d_data_d;

  logic                  req_i, req_d, gnt_i, gnt_d;
  logic [ADDR_WIDTH-1:0] req_addr_i, req_addr_d;
  logic                  owner_abort, ok_pulse, flt_pulse;

  ptw_req_slot #(.ADDR_WIDTH(ADDR_WIDTH)) u_slot_i (
    .clk(clk), .rst_n(rst_n), .addr_valid(i_addr_valid), .addr(i_addr),
    .abort(i_abort), .grant(gnt_i), .req(req_i), .req_addr(req_addr_i)
  );

  ptw_req_slot #(.ADDR_WIDTH(ADDR_WIDTH)) u_slot_d (
    .clk(clk), .rst_n(rst_n), .addr_valid(d_addr_valid), .addr(d_addr),
    .abort(d_abort), .grant(gnt_d), .req(req_d), .req_addr(req_addr_d)
  );

  // I wins a contested grant only when D went last.
  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (state_q == ST_IDLE) begin
      if (req_i && (!req_d || last_grant_q == PORT_D)) begin
        gnt_i = 1'b1;
      end else if (req_d) begin
        gnt_d = 1'b1;
      end
    end
  end

  assign owner_abort = (owner_q == PORT_I) ? i_abort : d_abort;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    drop_d       = drop_q;
    wait_d       = wait_q;
    araddr_d     = araddr_q;
    ok_pulse     = 1'b0;
    flt_pulse    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        drop_d = 1'b0;
        if (gnt_i || gnt_d) begin
          owner_d      = gnt_d ? PORT_D : PORT_I;
          last_grant_d = gnt_d ? PORT_D : PORT_I;
          araddr_d     = gnt_d ? req_addr_d : req_addr_i;
          state_d      = ST_AR;
        end
      end
      ST_AR: begin
        if (owner_abort) drop_d = 1'b1;
        if (m_arready) begin
          state_d = ST_R;
          wait_d  = '0;
        end
      end
      ST_R: begin
        if (owner_abort) drop_d = 1'b1;
        if (m_rvalid) begin
          state_d = ST_IDLE;
          if (!(drop_q || owner_abort)) begin
            ok_pulse  = (m_rresp == RRESP_OKAY);
            flt_pulse = (m_rresp != RRESP_OKAY);
          end
        end else if (TIMEOUT_EN && wait_q == WAIT_MAX) begin
          // The beat may still arrive; DRAIN swallows it so the slave is not left hanging.
          state_d   = ST_DRAIN;
          flt_pulse = !(drop_q || owner_abort);
        end else if (wait_q != WAIT_MAX) begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (owner_abort) drop_d = 1'b1;
        if (m_rvalid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    i_dv_d   = ok_pulse  && (owner_q == PORT_I);
    d_dv_d   = ok_pulse  && (owner_q == PORT_D);
    i_flt_d  = flt_pulse && (owner_q == PORT_I);
    d_flt_d  = flt_pulse && (owner_q == PORT_D);
    i_data_d = i_dv_d ? m_rdata : i_data_q;
    d_data_d = d_dv_d ? m_rdata : d_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= PORT_I;
      last_grant_q <= PORT_D;
      drop_q       <= 1'b0;
      wait_q       <= '0;
      araddr_q     <= '0;
      i_dv_q       <= 1'b0;
      d_dv_q       <= 1'b0;
      i_flt_q      <= 1'b0;
      d_flt_q      <= 1'b0;
      i_data_q     <= '0;
      d_data_q     <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      drop_q       <= drop_d;
      wait_q       <= wait_d;
      araddr_q     <= araddr_d;
      i_dv_q       <= i_dv_d;
      d_dv_q       <= d_dv_d;
      i_flt_q      <= i_flt_d;
      d_flt_q      <= d_flt_d;
      i_data_q     <= i_data_d;
      d_data_q     <= d_data_d;
    end
  end

  assign m_arvalid      = (state_q == ST_AR);
  assign m_araddr       = araddr_q;
  assign m_rready       = (state_q == ST_R) || (state_q == ST_DRAIN);
  assign busy           = (state_q != ST_IDLE);
  assign i_data_valid   = i_dv_q;
  assign d_data_valid   = d_dv_q;
  assign i_access_fault = i_flt_q;
  assign d_access_fault = d_flt_q;
  assign i_data         = i_data_q;
  assign d_data         = d_data_q;

endmodule

// File: tb/tb_ptw_axi_arbiter.sv
// tb/tb_ptw_axi_arbiter.sv - directed vector bench for ptw_axi_arbiter
module tb_ptw_axi_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_addr_valid, d_addr_valid, i_abort, d_abort;
  logic [63:0] i_addr, d_addr;
  logic        i_data_valid, d_data_valid, i_access_fault, d_access_fault;
  logic [63:0] i_data, d_data;
  logic        m_arvalid, m_arready, m_rvalid, m_rready, busy;
  logic [63:0] m_araddr, m_rdata;
  logic [1:0]  m_rresp;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ptw_axi_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_addr_valid(i_addr_valid), .d_addr_valid(d_addr_valid),
    .i_addr(i_addr), .d_addr(d_addr), .i_abort(i_abort), .d_abort(d_abort),
    .i_data_valid(i_data_valid), .d_data_valid(d_data_valid),
    .i_data(i_data), .d_data(d_data),
    .i_access_fault(i_access_fault), .d_access_fault(d_access_fault),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rready(m_rready),
    .busy(busy)
  );

  typedef struct {
    logic        iav;  logic [63:0] iaddr;
    logic        dav;  logic [63:0] daddr;
    logic        arr;  logic        rv;   logic [63:0] rdata; logic [1:0] rresp;
    logic        arv;  logic [63:0] araddr; logic rr; logic bsy;
    logic        idv;  logic [63:0] idata;
    logic        ddv;  logic [63:0] ddata;
    logic        ifl;  logic        dfl;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic iav, input logic [63:0] iaddr, input logic dav, input logic [63:0] daddr,
                     input logic arr, input logic rv, input logic [63:0] rdata, input logic [1:0] rresp,
                     input logic arv, input logic [63:0] araddr, input logic rr, input logic bsy,
                     input logic idv, input logic [63:0] idata, input logic ddv, input logic [63:0] ddata,
                     input logic ifl, input logic dfl);
    vec_t v;
    v.iav = iav; v.iaddr = iaddr; v.dav = dav; v.daddr = daddr;
    v.arr = arr; v.rv = rv; v.rdata = rdata; v.rresp = rresp;
    v.arv = arv; v.araddr = araddr; v.rr = rr; v.bsy = bsy;
    v.idv = idv; v.idata = idata; v.ddv = ddv; v.ddata = ddata;
    v.ifl = ifl; v.dfl = dfl;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_addr_valid = 0; d_addr_valid = 0; i_abort = 0; d_abort = 0;
    m_arready = 0; m_rvalid = 0; m_rresp = 2'b00;
  endtask

  initial begin
    rst_n = 0; i_addr = 0; d_addr = 0; m_rdata = 0;
    clear_inputs();

    //   iav iaddr          dav daddr    arr rv rdata           rresp | arv araddr          rr bsy idv idata           ddv ddata  ifl dfl
    add(1, 64'h1000,        1, 64'h2000, 0, 0, 0,               2'b00, 0, 64'h0,           0, 0,  0, 64'h0,          0, 64'h0,  0, 0);
    add(0, 0,               0, 0,        1, 0, 0,               2'b00, 1, 64'h1000,        0, 1,  0, 64'h0,          0, 64'h0,  0, 0);
    add(0, 0,               0, 0,        0, 1, 64'h11,          2'b00, 0, 64'h1000,        1, 1,  0, 64'h0,          0, 64'h0,  0, 0);
    add(0, 0,               0, 0,        0, 0, 0,               2'b00, 0, 64'h1000,        0, 0,  1, 64'h11,         0, 64'h0,  0, 0);
    add(0, 0,               0, 0,        1, 0, 0,               2'b00, 1, 64'h2000,        0, 1,  0, 64'h11,         0, 64'h0,  0, 0);
    add(0, 0,               0, 0,        0, 1, 64'h22,          2'b00, 0, 64'h2000,        1, 1,  0, 64'h11,         0, 64'h0,  0, 0);
    add(0, 0,               0, 0,        0, 0, 0,               2'b00, 0, 64'h2000,        0, 0,  0, 64'h11,         1, 64'h22, 0, 0);
    add(1, 64'h8000_1000,   0, 0,        0, 0, 0,               2'b00, 0, 64'h2000,        0, 0,  0, 64'h11,         0, 64'h22, 0, 0);
    add(0, 0,               0, 0,        1, 0, 0,               2'b00, 1, 64'h8000_1000,   0, 1,  0, 64'h11,         0, 64'h22, 0, 0);
    add(0, 0,               0, 0,        0, 1, 64'h2000_00CF,   2'b00, 0, 64'h8000_1000,   1, 1,  0, 64'h11,         0, 64'h22, 0, 0);
    add(0, 0,               0, 0,        0, 0, 0,               2'b00, 0, 64'h8000_1000,   0, 0,  1, 64'h2000_00CF,  0, 64'h22, 0, 0);
    add(1, 64'h3000,        1, 64'h4000, 0, 0, 0,               2'b00, 0, 64'h8000_1000,   0, 0,  0, 64'h2000_00CF,  0, 64'h22, 0, 0);
    add(0, 0,               0, 0,        1, 0, 0,               2'b00, 1, 64'h4000,        0, 1,  0, 64'h2000_00CF,  0, 64'h22, 0, 0);
    add(0, 0,               0, 0,        0, 1, 64'h44,          2'b00, 0, 64'h4000,        1, 1,  0, 64'h2000_00CF,  0, 64'h22, 0, 0);
    add(0, 0,               0, 0,        0, 0, 0,               2'b00, 0, 64'h4000,        0, 0,  0, 64'h2000_00CF,  1, 64'h44, 0, 0);
    add(0, 0,               0, 0,        1, 0, 0,               2'b00, 1, 64'h3000,        0, 1,  0, 64'h2000_00CF,  0, 64'h44, 0, 0);
    add(0, 0,               0, 0,        0, 1, 64'h33,          2'b00, 0, 64'h3000,        1, 1,  0, 64'h2000_00CF,  0, 64'h44, 0, 0);
    add(0, 0,               0, 0,        0, 0, 0,               2'b00, 0, 64'h3000,        0, 0,  1, 64'h33,         0, 64'h44, 0, 0);
    add(0, 0,               1, 64'h5000, 0, 0, 0,               2'b00, 0, 64'h3000,        0, 0,  0, 64'h33,         0, 64'h44, 0, 0);
    add(0, 0,               0, 0,        0, 0, 0,               2'b00, 1, 64'h5000,        0, 1,  0, 64'h33,         0, 64'h44, 0, 0);
    add(0, 0,               0, 0,        1, 0, 0,               2'b00, 1, 64'h5000,        0, 1,  0, 64'h33,         0, 64'h44, 0, 0);
    add(0, 0,               0, 0,        0, 1, 64'hDEAD,        2'b10, 0, 64'h5000,        1, 1,  0, 64'h33,         0, 64'h44, 0, 0);
    add(0, 0,               0, 0,        0, 0, 0,               2'b00, 0, 64'h5000,        0, 0,  0, 64'h33,         0, 64'h44, 0, 1);
    add(0, 0,               0, 0,        0, 0, 0,               2'b00, 0, 64'h5000,        0, 0,  0, 64'h33,         0, 64'h44, 0, 0);

    tick();
    tick();
    chk("reset busy", busy, 0);
    chk("reset arvalid", m_arvalid, 0);
    chk("reset rready", m_rready, 0);
    chk("reset pulses", {i_data_valid, d_data_valid, i_access_fault, d_access_fault}, 0);
    chk("reset data", i_data | d_data, 0);
    rst_n = 1;
    tick();

    for (int k = 0; k < tbl.size(); k++) begin
      i_addr_valid = tbl[k].iav; i_addr = tbl[k].iaddr;
      d_addr_valid = tbl[k].dav; d_addr = tbl[k].daddr;
      m_arready = tbl[k].arr; m_rvalid = tbl[k].rv; m_rdata = tbl[k].rdata; m_rresp = tbl[k].rresp;
      chk($sformatf("row%0d arvalid", k), m_arvalid, tbl[k].arv);
      chk($sformatf("row%0d araddr", k), m_araddr, tbl[k].araddr);
      chk($sformatf("row%0d rready", k), m_rready, tbl[k].rr);
      chk($sformatf("row%0d busy", k), busy, tbl[k].bsy);
      chk($sformatf("row%0d i_data_valid", k), i_data_valid, tbl[k].idv);
      chk($sformatf("row%0d i_data", k), i_data, tbl[k].idata);
      chk($sformatf("row%0d d_data_valid", k), d_data_valid, tbl[k].ddv);
      chk($sformatf("row%0d d_data", k), d_data, tbl[k].ddata);
      chk($sformatf("row%0d i_fault", k), i_access_fault, tbl[k].ifl);
      chk($sformatf("row%0d d_fault", k), d_access_fault, tbl[k].dfl);
      tick();
    end
    clear_inputs();

    // Timeout: R waits 4 counted cycles, faults, then drains a late beat.
    d_addr_valid = 1; d_addr = 64'h6000;
    tick();
    d_addr_valid = 0;
    chk("to arvalid", m_arvalid, 1);
    chk("to araddr", m_araddr, 64'h6000);
    m_arready = 1;
    tick();
    m_arready = 0;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("to rready c%0d", k), m_rready, 1);
      chk($sformatf("to d_fault c%0d", k), d_access_fault, (k == 5));
      chk($sformatf("to d_data_valid c%0d", k), d_data_valid, 0);
      chk($sformatf("to busy c%0d", k), busy, 1);
      tick();
    end
    m_rvalid = 1; m_rdata = 64'hBAD;
    chk("to drain rready", m_rready, 1);
    tick();
    m_rvalid = 0;
    chk("to idle busy", busy, 0);
    chk("to late d_data_valid", d_data_valid, 0);
    chk("to late d_fault", d_access_fault, 0);
    chk("to late d_data", d_data, 64'h44);

    // Abort of the in-flight I walk while D is queued.
    i_addr_valid = 1; i_addr = 64'h7000;
    tick();
    i_addr_valid = 0;
    chk("ab arvalid", m_arvalid, 1);
    chk("ab araddr", m_araddr, 64'h7000);
    m_arready = 1;
    tick();
    m_arready = 0;
    chk("ab rready", m_rready, 1);
    d_addr_valid = 1; d_addr = 64'h8000;
    tick();
    d_addr_valid = 0;
    i_abort = 1;
    tick();
    i_abort = 0;
    m_rvalid = 1; m_rdata = 64'h77;
    chk("ab rready2", m_rready, 1);
    tick();
    m_rvalid = 0;
    chk("ab idle busy", busy, 0);
    chk("ab i_data_valid", i_data_valid, 0);
    chk("ab i_fault", i_access_fault, 0);
    tick();
    chk("ab d arvalid", m_arvalid, 1);
    chk("ab d araddr", m_araddr, 64'h8000);
    chk("ab i_data_valid2", i_data_valid, 0);
    m_arready = 1;
    tick();
    m_arready = 0;
    m_rvalid = 1; m_rdata = 64'h88;
    tick();
    m_rvalid = 0;
    chk("ab d_data_valid", d_data_valid, 1);
    chk("ab d_data", d_data, 64'h88);
    chk("ab i_data kept", i_data, 64'h33);

    // Reset while in AR with D pending.
    i_addr_valid = 1; i_addr = 64'h9000;
    tick();
    i_addr_valid = 0;
    chk("rs arvalid", m_arvalid, 1);
    d_addr_valid = 1; d_addr = 64'hA000;
    tick();
    d_addr_valid = 0;
    chk("rs still ar", m_arvalid, 1);
    #2 rst_n = 0;
    #1;
    chk("rs arvalid now", m_arvalid, 0);
    chk("rs busy now", busy, 0);
    chk("rs rready now", m_rready, 0);
    chk("rs araddr now", m_araddr, 0);
    chk("rs data now", i_data | d_data, 0);
    tick();
    tick();
    rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("rs post busy c%0d", k), busy, 0);
      chk($sformatf("rs post arvalid c%0d", k), m_arvalid, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
